// File: rtl/wl_pkg.sv
// rtl/wl_pkg.sv - shared states, default sizes and geometry helpers for weight_loader_pp
package wl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } wl_state_e;

  localparam int WL_WW_DEF = 16;
  localparam int WL_TM_DEF = 4;
  localparam int WL_TN_DEF = 16;

  // Bit offset of lane m inside one stream beat.
  function automatic int lane_lsb(input int m, input int ww);
    return m * ww;
  endfunction

  // Bit offset of element [m][n] inside a flattened TM x TN bank.
  function automatic int elem_lsb(input int m, input int n, input int tn, input int ww);
    return (m * tn + n) * ww;
  endfunction

  // Stream width must carry exactly one weight per row lane.
  function automatic bit dw_ok(input int dw, input int tm, input int ww);
    return dw == tm * ww;
  endfunction

endpackage

// File: rtl/weight_loader_pp_if.sv
// rtl/weight_loader_pp_if.sv - weight column stream between producer and loader
interface weight_loader_pp_if #(
  parameter int DW = 64
);
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/wl_bank.sv
// rtl/wl_bank.sv - TM x TN weight register bank with clear and column write
module wl_bank
  import wl_pkg::*;
#(
  parameter int WW = WL_WW_DEF,
  parameter int TM = WL_TM_DEF,
  parameter int TN = WL_TN_DEF,
  parameter int CW = $clog2(TN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [CW-1:0]      col,
  input  logic [TM*WW-1:0]   din,
  output logic [TM*TN*WW-1:0] dout
);

  logic [TM*TN*WW-1:0] mem;

  // Clear wins over write so a fresh load always starts from an all-zero bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (we) begin
      for (int m = 0; m < TM; m++) begin
        mem[elem_lsb(m, int'(col), TN, WW) +: WW] <= din[lane_lsb(m, WW) +: WW];
      end
    end
  end

  assign dout = mem;

endmodule

// File: rtl/weight_loader_pp.sv
// rtl/weight_loader_pp.sv - ping-pong weight loader; WL_TLAST_CHECK_EN enables tlast framing check
module weight_loader_pp
  import wl_pkg::*;
#(
  parameter int WW = WL_WW_DEF,
  parameter int TM = WL_TM_DEF,
  parameter int TN = WL_TN_DEF,
  parameter int DW = TM * WW,
  parameter int CW = $clog2(TN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       num_col,
  weight_loader_pp_if.slave   s,
  input  logic                swap_req,
  output logic [TM*TN*WW-1:0] weight,
  output logic                weight_valid,
  output logic                bank_sel,
  output logic                load_done,
  output logic                busy,
  output logic                err
);

  localparam bit DW_OK = dw_ok(DW, TM, WW);

  if (!DW_OK) begin : g_dw_bad
    $error("weight_loader_pp: DW must equal TM*WW");
  end

  wl_state_e state_q, state_d;

  logic [CW-1:0] col_cnt;
  logic [CW-1:0] num_col_r;
  logic [CW-1:0] num_col_clamp;

  logic start_acc;
  logic beat;
  logic last_beat;
  logic swap;
  logic shd_clr;
  logic shd_we;

  logic [TM*TN*WW-1:0] dout0, dout1;

  // Requests beyond the tile width load the whole tile.
  always_comb begin
    num_col_clamp = num_col;
    if (int'(num_col) > TN - 1) begin
      num_col_clamp = CW'(TN - 1);
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    swap      = 1'b0;
    shd_clr   = 1'b0;
    shd_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          shd_clr   = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (s.tvalid) begin
          beat   = 1'b1;
          shd_we = 1'b1;
          if (col_cnt == num_col_r) begin
            last_beat = 1'b1;
            state_d   = FULL;
          end
        end
      end
      FULL: begin
        if (swap_req) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Column counter, bank select and completion flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt      <= '0;
      num_col_r    <= '0;
      bank_sel     <= 1'b0;
      weight_valid <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      load_done <= last_beat;
      if (start_acc) begin
        num_col_r <= num_col_clamp;
        col_cnt   <= '0;
      end else if (beat && !last_beat) begin
        col_cnt <= col_cnt + 1'b1;
      end
      if (swap) begin
        bank_sel     <= ~bank_sel;
        weight_valid <= 1'b1;
      end
    end
  end

`ifdef WL_TLAST_CHECK_EN
  // Sticky framing error: tlast must mark exactly the final counted beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (beat && (s.tlast != (col_cnt == num_col_r))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s.tlast;
  assign err = 1'b0;
`endif

  assign s.tready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);

  // The shadow bank is always the one not selected, so loads never touch the active bank.
  wl_bank #(.WW(WW), .TM(TM), .TN(TN), .CW(CW)) u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .clr  (shd_clr & bank_sel),
    .we   (shd_we & bank_sel),
    .col  (col_cnt),
    .din  (s.tdata),
    .dout (dout0)
  );

  wl_bank #(.WW(WW), .TM(TM), .TN(TN), .CW(CW)) u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .clr  (shd_clr & ~bank_sel),
    .we   (shd_we & ~bank_sel),
    .col  (col_cnt),
    .din  (s.tdata),
    .dout (dout1)
  );

  assign weight = bank_sel ? dout1 : dout0;

endmodule

// File: tb/tb_weight_loader_pp.sv
// tb/tb_weight_loader_pp.sv - self-checking bench for weight_loader_pp
module tb_weight_loader_pp;
  localparam int WW = 16;
  localparam int TM = 4;
  localparam int TN = 16;
  localparam int DW = TM * WW;
  localparam int CW = $clog2(TN);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                swap_req = 1'b0;
  logic [CW-1:0]       num_col = '0;
  logic [TM*TN*WW-1:0] weight;
  logic                weight_valid, bank_sel, load_done, busy, err;

  weight_loader_pp_if #(.DW(DW)) s_if ();

  weight_loader_pp #(.WW(WW), .TM(TM), .TN(TN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_col      (num_col),
    .s            (s_if),
    .swap_req     (swap_req),
    .weight       (weight),
    .weight_valid (weight_valid),
    .bank_sel     (bank_sel),
    .load_done    (load_done),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: the image the PE array sees and the image being assembled.
  logic [WW-1:0] act [TM][TN];
  logic [WW-1:0] shd [TM][TN];
  logic          exp_sel   = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_err   = 1'b0;

  function automatic logic [TM*TN*WW-1:0] flat_act();
    logic [TM*TN*WW-1:0] f;
    for (int m = 0; m < TM; m++)
      for (int n = 0; n < TN; n++)
        f[(m*TN+n)*WW +: WW] = act[m][n];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag);
    logic [TM*TN*WW-1:0] e;
    int bad;
    e   = flat_act();
    bad = 0;
    for (int i = TM*TN-1; i >= 0; i--)
      if (weight[i*WW +: WW] !== e[i*WW +: WW]) bad = i;
    n_checks++;
    assert (weight === e) else begin
      n_err++;
      $error("FAIL %s elem=%0d observed=%0h expected=%0h", tag, bad, weight[bad*WW +: WW], e[bad*WW +: WW]);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < TM; m++)
      for (int n = 0; n < TN; n++) begin
        act[m][n] = '0;
        shd[m][n] = '0;
      end
    exp_sel   = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk_w({tag, "_weight"});
    chk({tag, "_weight_valid"}, 32'(weight_valid), 0);
    chk({tag, "_bank_sel"}, 32'(bank_sel), 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_tready"}, 32'(s_if.tready), 0);
  endtask

  // mode 0: lane m of beat c = m*256+c; mode 1: random data.
  // bad_tlast >= 0 puts tlast on that beat only; abort_after >= 0 stops after that many beats.
  task automatic do_load(input int n, input int mode, input bit gaps, input bit noise,
                         input int bad_tlast, input int abort_after, input int hold);
    int beats, sent, cyc, done_cnt;
    bit v, rdy;
    logic [WW-1:0] lane [TM];
    beats    = (n > TN - 1) ? TN : n + 1;
    sent     = 0;
    cyc      = 0;
    done_cnt = 0;
    @(negedge clk);
    start   = 1'b1;
    num_col = CW'(n);
    @(negedge clk);
    start = 1'b0;
    for (int m = 0; m < TM; m++)
      for (int c = 0; c < TN; c++)
        shd[m][c] = '0;
`ifdef WL_TLAST_CHECK_EN
    exp_err = 1'b0;
`endif
    chk("busy_in_load", 32'(busy), 1);
    chk("err_after_start", 32'(err), 32'(exp_err));
    while (sent < beats && cyc < 2000) begin
      if (abort_after >= 0 && sent == abort_after) break;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int m = 0; m < TM; m++) begin
        lane[m] = (mode == 0) ? WW'(m * 256 + sent) : WW'($urandom);
        s_if.tdata[m*WW +: WW] = lane[m];
      end
      s_if.tvalid = v;
      s_if.tlast  = (bad_tlast >= 0) ? (sent == bad_tlast) : (sent == beats - 1);
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        swap_req = 1'($urandom_range(0, 1));
      end
      #1 rdy = s_if.tready;
      @(negedge clk);
      if (load_done) done_cnt++;
      if (v && rdy) begin
        for (int m = 0; m < TM; m++) shd[m][sent] = lane[m];
`ifdef WL_TLAST_CHECK_EN
        if (s_if.tlast != (sent == beats - 1)) exp_err = 1'b1;
`endif
        sent++;
        if (sent == beats) chk("load_done_on_last_beat", 32'(load_done), 1);
      end
      cyc++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    start       = 1'b0;
    swap_req    = 1'b0;
    if (abort_after < 0) begin
      chk("beats_accepted", 32'(sent), 32'(beats));
      for (int k = 0; k < 3; k++) begin
        s_if.tvalid = 1'b1;
        #1 chk("tready_low_in_full", 32'(s_if.tready), 0);
        @(negedge clk);
        if (load_done) done_cnt++;
      end
      s_if.tvalid = 1'b0;
      chk("load_done_pulses", 32'(done_cnt), 1);
      chk("busy_in_full", 32'(busy), 1);
      chk("err_after_load", 32'(err), 32'(exp_err));
      chk_w("active_untouched_by_load");
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk_w("active_held_without_swap");
      end
    end
  endtask

  task automatic do_swap();
    logic [WW-1:0] t;
    @(negedge clk);
    swap_req = 1'b1;
    #1 chk_w("weight_before_swap_edge");
    @(negedge clk);
    swap_req = 1'b0;
    for (int m = 0; m < TM; m++)
      for (int c = 0; c < TN; c++) begin
        t         = act[m][c];
        act[m][c] = shd[m][c];
        shd[m][c] = t;
      end
    exp_sel   = ~exp_sel;
    exp_valid = 1'b1;
    chk_w("weight_after_swap");
    chk("bank_sel_after_swap", 32'(bank_sel), 32'(exp_sel));
    chk("weight_valid_after_swap", 32'(weight_valid), 32'(exp_valid));
    chk("busy_after_swap", 32'(busy), 0);
    chk("tready_low_in_idle", 32'(s_if.tready), 0);
    chk("err_after_swap", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] orv;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_reset("reset");

    // swap_req in IDLE is ignored.
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    chk("idle_swap_ignored_sel", 32'(bank_sel), 0);
    chk("idle_swap_ignored_valid", 32'(weight_valid), 0);

    // Full load with the index pattern.
    do_load(15, 0, 1'b0, 1'b0, -1, -1, 0);
    do_swap();
    chk("full_elem_0_0", 32'(weight[(0*16+0)*16 +: 16]), 32'd0);
    chk("full_elem_3_15", 32'(weight[(3*16+15)*16 +: 16]), 32'(3*256+15));
    chk("full_elem_2_7", 32'(weight[(2*16+7)*16 +: 16]), 32'(2*256+7));

    // Partial load: columns 4..15 must read zero.
    do_load(3, 1, 1'b0, 1'b0, -1, -1, 0);
    do_swap();
    orv = '0;
    for (int m = 0; m < TM; m++)
      for (int c = 4; c < TN; c++)
        orv = orv | weight[(m*TN+c)*WW +: WW];
    chk("partial_upper_cols_zero", 32'(orv), 0);

    // num_col=0 loads exactly one column.
    do_load(0, 1, 1'b0, 1'b0, -1, -1, 0);
    do_swap();

    // Largest request: whole tile, exactly TN beats.
    do_load(15, 1, 1'b0, 1'b0, -1, -1, 0);
    do_swap();

    // Ping-pong with gaps and ignored start/swap during LOAD, held 50 cycles.
    do_load(15, 1, 1'b1, 1'b1, -1, -1, 50);
    do_swap();

    // Backpressure on the index pattern gives the full-load image.
    do_load(15, 0, 1'b1, 1'b0, -1, -1, 0);
    do_swap();
    chk("bp_elem_1_9", 32'(weight[(1*16+9)*16 +: 16]), 32'(1*256+9));

    // Reset after 7 beats discards the partial load.
    do_load(15, 1, 1'b0, 1'b0, -1, 7, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk_reset("midload_reset");
    do_load(15, 1, 1'b1, 1'b0, -1, -1, 0);
    do_swap();

    // Misplaced tlast, then a correctly framed load.
    do_load(15, 1, 1'b0, 1'b0, 4, -1, 5);
    do_swap();
    do_load(15, 1, 1'b0, 1'b0, -1, -1, 0);
    do_swap();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
